// File: rtl/vga_timing_pkg.sv
// Shared VGA timing presets, the registered sync-flag bundle and the
// elaboration-time legality check used by the timing generator.
package vga_timing_pkg;

  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;

  localparam int unsigned VGA800_H_ACTIVE = 800;
  localparam int unsigned VGA800_H_FP     = 40;
  localparam int unsigned VGA800_H_SYNC   = 128;
  localparam int unsigned VGA800_H_BP     = 88;
  localparam int unsigned VGA800_V_ACTIVE = 600;
  localparam int unsigned VGA800_V_FP     = 1;
  localparam int unsigned VGA800_V_SYNC   = 4;
  localparam int unsigned VGA800_V_BP     = 23;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    logic line_start;
    logic frame_start;
  } sync_flags_t;

  // Both totals must fit the coordinate width, no interval may be empty,
  // and the divider only supports 1..16 clocks per pixel.
  function automatic bit timing_legal(input int unsigned cw, ha, hf, hs, hb,
                                      va, vf, vs, vb, clkDiv);
    longint unsigned hTotal;
    longint unsigned vTotal;
    longint unsigned limit;
    hTotal = 64'(ha) + 64'(hf) + 64'(hs) + 64'(hb);
    vTotal = 64'(va) + 64'(vf) + 64'(vs) + 64'(vb);
    limit  = 64'd1 << cw;
    return (cw != 0) && (cw < 32) && (hTotal <= limit) && (vTotal <= limit) &&
           (ha != 0) && (hf != 0) && (hs != 0) && (hb != 0) &&
           (va != 0) && (vf != 0) && (vs != 0) && (vb != 0) &&
           (clkDiv >= 1) && (clkDiv <= 16);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Pixel clock-enable divider: one tick per CLK_DIV clocks while enabled.
module clk_en_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam logic [3:0] CNT_LAST = 4'(CLK_DIV - 1);

  if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_bad_div
    $error("clk_en_div: CLK_DIV must be within 1..16");
  end

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Gating with reset keeps tick low through reset even when CLK_DIV is 1.
  assign tick = en && !reset && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line counters plus registered sync, blanking
// and coordinate outputs, all aligned one clock after the counter state.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
  parameter int unsigned H_FP     = VGA640_H_FP,
  parameter int unsigned H_SYNC   = VGA640_H_SYNC,
  parameter int unsigned H_BP     = VGA640_H_BP,
  parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
  parameter int unsigned V_FP     = VGA640_V_FP,
  parameter int unsigned V_SYNC   = VGA640_V_SYNC,
  parameter int unsigned V_BP     = VGA640_V_BP,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CW       = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          tick,
  output logic [CW-1:0] pixelx,
  output logic [CW-1:0] pixely,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT        = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT        = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] V_SYNC_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (!timing_legal(CW, H_ACTIVE, H_FP, H_SYNC, H_BP,
                    V_ACTIVE, V_FP, V_SYNC, V_BP, CLK_DIV)) begin : g_bad_params
    $error("vga_timing_gen: illegal timing parameter set");
  end

  logic        divTick;
  logic [CW-1:0] hCnt_q, hCnt_d;
  logic [CW-1:0] vCnt_q, vCnt_d;
  logic [CW-1:0] pixelx_q, pixely_q;
  sync_flags_t flags_q, flags_d;

  clk_en_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .tick (divTick)
  );

  // A horizontal wrap carries into the vertical counter on the same tick.
  always_comb begin
    hCnt_d = hCnt_q;
    vCnt_d = vCnt_q;
    if (divTick) begin
      if (hCnt_q == H_LAST) begin
        hCnt_d = '0;
        vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 1'b1;
      end else begin
        hCnt_d = hCnt_q + 1'b1;
      end
    end
  end

  // Flags decode the current counters so they land with the coordinates.
  always_comb begin
    flags_d.hsync       = ((hCnt_q >= H_SYNC_FIRST) && (hCnt_q <= H_SYNC_LAST)) ? H_POL : ~H_POL;
    flags_d.vsync       = ((vCnt_q >= V_SYNC_FIRST) && (vCnt_q <= V_SYNC_LAST)) ? V_POL : ~V_POL;
    flags_d.video_on    = (hCnt_q < H_ACT) && (vCnt_q < V_ACT);
    flags_d.line_start  = (hCnt_q == '0) && (pixelx_q != '0);
    flags_d.frame_start = (hCnt_q == '0) && (pixelx_q != '0) && (vCnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hCnt_q   <= '0;
      vCnt_q   <= '0;
      pixelx_q <= '0;
      pixely_q <= '0;
      flags_q  <= '{hsync: ~H_POL, vsync: ~V_POL, video_on: 1'b1,
                    line_start: 1'b0, frame_start: 1'b0};
    end else if (en) begin
      hCnt_q   <= hCnt_d;
      vCnt_q   <= vCnt_d;
      pixelx_q <= hCnt_q;
      pixely_q <= vCnt_q;
      flags_q  <= flags_d;
    end else begin
      flags_q.line_start  <= 1'b0;
      flags_q.frame_start <= 1'b0;
    end
  end

  assign tick        = divTick;
  assign pixelx      = pixelx_q;
  assign pixely      = pixely_q;
  assign hsync       = flags_q.hsync;
  assign vsync       = flags_q.vsync;
  assign video_on    = flags_q.video_on;
  assign line_start  = flags_q.line_start;
  assign frame_start = flags_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480, a tiny timing set for
// whole-frame behaviour, and 800x600 with CLK_DIV=1 and positive syncs.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, en0, hs0, vs0, vo0, tk0, ls0, fs0;
  logic [10:0] px0, py0;
  logic rst1, en1, hs1, vs1, vo1, tk1, ls1, fs1;
  logic [10:0] px1, py1;
  logic rst2, en2, hs2, vs2, vo2, tk2, ls2, fs2;
  logic [3:0] px2, py2;

  int testsRun = 0;
  int testsFailed = 0;

  vga_timing_gen dut0 (
    .clk(clk), .reset(rst0), .en(en0), .hsync(hs0), .vsync(vs0), .video_on(vo0),
    .tick(tk0), .pixelx(px0), .pixely(py0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_ACTIVE(VGA800_H_ACTIVE), .H_FP(VGA800_H_FP), .H_SYNC(VGA800_H_SYNC), .H_BP(VGA800_H_BP),
    .V_ACTIVE(VGA800_V_ACTIVE), .V_FP(VGA800_V_FP), .V_SYNC(VGA800_V_SYNC), .V_BP(VGA800_V_BP),
    .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .CW(11)
  ) dut1 (
    .clk(clk), .reset(rst1), .en(en1), .hsync(hs1), .vsync(vs1), .video_on(vo1),
    .tick(tk1), .pixelx(px1), .pixely(py1), .line_start(ls1), .frame_start(fs1)
  );

  // 15 pixels x 8 lines at 3 clocks per pixel: one frame is 360 clocks.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(3), .CW(4)
  ) dut2 (
    .clk(clk), .reset(rst2), .en(en2), .hsync(hs2), .vsync(vs2), .video_on(vo2),
    .tick(tk2), .pixelx(px2), .pixely(py2), .line_start(ls2), .frame_start(fs2)
  );

  task automatic stepClk();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
    stepClk();
    stepClk();
    testsRun++; if (px0 !== 11'd0 || py0 !== 11'd0) begin testsFailed++; $display("[TB] FAIL reset_pos: got (%0d,%0d) want (0,0)", px0, py0); end
    testsRun++; if ({hs0, vs0, vo0} !== 3'b111) begin testsFailed++; $display("[TB] FAIL reset_sync: got hs/vs/vo=%b want 111", {hs0, vs0, vo0}); end
    testsRun++; if ({tk0, ls0, fs0} !== 3'b000) begin testsFailed++; $display("[TB] FAIL reset_pulses: got tick/ls/fs=%b want 000", {tk0, ls0, fs0}); end
    testsRun++; if ({hs1, vs1, vo1} !== 3'b001) begin testsFailed++; $display("[TB] FAIL reset_pos_pol: got hs/vs/vo=%b want 001", {hs1, vs1, vo1}); end
    testsRun++; if (tk1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_div1_tick: got %b want 0", tk1); end
    testsRun++; if (px2 !== 4'd0 || tk2 !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_small: got px=%0d tick=%b want 0/0", px2, tk2); end
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
  endtask

  task automatic test_default_line();
    int badTick = 0, badPos = 0, badHs = 0, badVs = 0, badVo = 0, badLs = 0, badFs = 0, hsLow = 0;
    int k, expPx, expPy;
    rst0 = 1'b1; en0 = 1'b1; stepClk(); rst0 = 1'b0;
    for (int n = 1; n <= 3212; n++) begin
      stepClk();
      k = (n - 1) / 4; expPx = k % 800; expPy = k / 800;
      if (tk0 !== ((n % 4) == 3)) badTick++;
      if (px0 !== 11'(expPx) || py0 !== 11'(expPy)) badPos++;
      if (hs0 !== !(expPx >= 656 && expPx <= 751)) badHs++;
      if (vs0 !== 1'b1) badVs++;
      if (vo0 !== (expPx < 640)) badVo++;
      if (ls0 !== (n == 3201)) badLs++;
      if (fs0 !== 1'b0) badFs++;
      if (hs0 === 1'b0) hsLow++;
    end
    testsRun++; if (badTick !== 0) begin testsFailed++; $display("[TB] FAIL default_tick: %0d clks off the 1-in-4 cadence, want 0", badTick); end
    testsRun++; if (badPos !== 0) begin testsFailed++; $display("[TB] FAIL default_coords: %0d clks with wrong (x,y), want 0", badPos); end
    testsRun++; if (badHs !== 0) begin testsFailed++; $display("[TB] FAIL default_hsync: %0d clks wrong, want 0", badHs); end
    testsRun++; if (badVs !== 0) begin testsFailed++; $display("[TB] FAIL default_vsync: %0d clks wrong, want 0", badVs); end
    testsRun++; if (badVo !== 0) begin testsFailed++; $display("[TB] FAIL default_video_on: %0d clks wrong, want 0", badVo); end
    testsRun++; if (badLs !== 0) begin testsFailed++; $display("[TB] FAIL default_line_start: %0d clks wrong (pulse due at clk 3201), want 0", badLs); end
    testsRun++; if (badFs !== 0) begin testsFailed++; $display("[TB] FAIL default_frame_start: %0d clks wrong, want 0", badFs); end
    testsRun++; if (hsLow !== 384) begin testsFailed++; $display("[TB] FAIL default_hsync_width: got %0d clks low want 384", hsLow); end
  endtask

  task automatic test_enable_freeze();
    int budget = 0, badHold = 0, resumeClks = 0;
    rst0 = 1'b1; en0 = 1'b1; stepClk(); rst0 = 1'b0;
    while (px0 !== 11'd300 && budget < 2000) begin stepClk(); budget++; end
    testsRun++; if (px0 !== 11'd300) begin testsFailed++; $display("[TB] FAIL freeze_reach300: got px=%0d want 300 within 2000 clks", px0); return; end
    en0 = 1'b0;
    for (int i = 0; i < 37; i++) begin
      stepClk();
      if (tk0 !== 1'b0 || ls0 !== 1'b0 || fs0 !== 1'b0) badHold++;
      if (px0 !== 11'd300 || py0 !== 11'd0 || {hs0, vs0, vo0} !== 3'b111) badHold++;
    end
    testsRun++; if (badHold !== 0) begin testsFailed++; $display("[TB] FAIL freeze_hold: %0d deviations while en=0, want 0", badHold); end
    en0 = 1'b1;
    while (px0 !== 11'd301 && resumeClks < 20) begin stepClk(); resumeClks++; end
    testsRun++; if (resumeClks !== 4) begin testsFailed++; $display("[TB] FAIL freeze_resume: px=301 after %0d clks want 4", resumeClks); end
  endtask

  task automatic test_reset_midline();
    int budget = 0, badLs = 0;
    while (px0 !== 11'd700 && budget < 2000) begin stepClk(); budget++; end
    testsRun++; if (px0 !== 11'd700) begin testsFailed++; $display("[TB] FAIL midline_reach700: got px=%0d want 700 within 2000 clks", px0); return; end
    testsRun++; if (hs0 !== 1'b0) begin testsFailed++; $display("[TB] FAIL midline_hsync_pre: got %b want 0 at px=700", hs0); end
    rst0 = 1'b1; stepClk(); rst0 = 1'b0;
    testsRun++; if (px0 !== 11'd0 || py0 !== 11'd0) begin testsFailed++; $display("[TB] FAIL midline_reset_pos: got (%0d,%0d) want (0,0)", px0, py0); end
    testsRun++; if ({hs0, vs0, vo0, ls0, fs0} !== 5'b11100) begin testsFailed++; $display("[TB] FAIL midline_reset_flags: got hs/vs/vo/ls/fs=%b want 11100", {hs0, vs0, vo0, ls0, fs0}); end
    for (int i = 1; i <= 5; i++) begin
      stepClk();
      if (ls0 !== 1'b0) badLs++;
      if (i == 4) begin
        testsRun++; if (px0 !== 11'd0) begin testsFailed++; $display("[TB] FAIL midline_restart_hold: got px=%0d want 0 after 4 clks", px0); end
      end
    end
    testsRun++; if (px0 !== 11'd1) begin testsFailed++; $display("[TB] FAIL midline_restart_step: got px=%0d want 1 after 5 clks", px0); end
    testsRun++; if (badLs !== 0) begin testsFailed++; $display("[TB] FAIL midline_no_line_start: %0d pulses want 0", badLs); end
    en0 = 1'b0;
  endtask

  task automatic test_small_frames();
    int badTick = 0, badPos = 0, badHs = 0, badVs = 0, badVo = 0, badLs = 0, badFs = 0;
    int k, expPx, expPy, fsCount = 0, fsFirst = -1, fsGap = 0;
    logic [3:0] wrapPx = '0, wrapPy = '0;
    logic [1:0] wrapPulses = '0;
    rst2 = 1'b1; en2 = 1'b1; stepClk(); rst2 = 1'b0;
    for (int n = 1; n <= 760; n++) begin
      stepClk();
      k = (n - 1) / 3; expPx = k % 15; expPy = (k / 15) % 8;
      if (tk2 !== ((n % 3) == 2)) badTick++;
      if (px2 !== 4'(expPx) || py2 !== 4'(expPy)) badPos++;
      if (hs2 !== !(expPx >= 10 && expPx <= 12)) badHs++;
      if (vs2 !== !(expPy >= 5 && expPy <= 6)) badVs++;
      if (vo2 !== (expPx < 8 && expPy < 4)) badVo++;
      if (ls2 !== (n > 1 && ((n - 1) % 45) == 0)) badLs++;
      if (fs2 !== (n > 1 && ((n - 1) % 360) == 0)) badFs++;
      if (n == 360) begin wrapPx = px2; wrapPy = py2; end
      if (n == 361) wrapPulses = {ls2, fs2};
      if (fs2 === 1'b1) begin
        fsCount++;
        if (fsFirst < 0) fsFirst = n; else fsGap = n - fsFirst;
      end
    end
    testsRun++; if (badTick !== 0) begin testsFailed++; $display("[TB] FAIL small_tick: %0d clks off the 1-in-3 cadence, want 0", badTick); end
    testsRun++; if (badPos !== 0) begin testsFailed++; $display("[TB] FAIL small_coords: %0d clks with wrong (x,y), want 0", badPos); end
    testsRun++; if (badHs !== 0) begin testsFailed++; $display("[TB] FAIL small_hsync: %0d clks wrong, want 0", badHs); end
    testsRun++; if (badVs !== 0) begin testsFailed++; $display("[TB] FAIL small_vsync: %0d clks wrong, want 0", badVs); end
    testsRun++; if (badVo !== 0) begin testsFailed++; $display("[TB] FAIL small_video_on: %0d clks wrong, want 0", badVo); end
    testsRun++; if (badLs !== 0) begin testsFailed++; $display("[TB] FAIL small_line_start: %0d clks wrong, want 0", badLs); end
    testsRun++; if (badFs !== 0) begin testsFailed++; $display("[TB] FAIL small_frame_start: %0d clks wrong, want 0", badFs); end
    testsRun++; if (wrapPx !== 4'd14 || wrapPy !== 4'd7) begin testsFailed++; $display("[TB] FAIL small_corner: got (%0d,%0d) want (14,7)", wrapPx, wrapPy); end
    testsRun++; if (wrapPulses !== 2'b11) begin testsFailed++; $display("[TB] FAIL small_wrap_pulses: got ls/fs=%b want 11", wrapPulses); end
    testsRun++; if (fsCount !== 2 || fsGap !== 360) begin testsFailed++; $display("[TB] FAIL small_frame_period: got %0d pulses %0d apart want 2 pulses 360 apart", fsCount, fsGap); end
  endtask

  task automatic test_small_reset_midframe();
    int budget = 0, badLs = 0;
    while (!(px2 === 4'd5 && py2 === 4'd2) && budget < 400) begin stepClk(); budget++; end
    testsRun++; if (px2 !== 4'd5 || py2 !== 4'd2) begin testsFailed++; $display("[TB] FAIL small_reach_mid: got (%0d,%0d) want (5,2) within 400 clks", px2, py2); return; end
    rst2 = 1'b1; stepClk(); rst2 = 1'b0;
    testsRun++; if (px2 !== 4'd0 || py2 !== 4'd0) begin testsFailed++; $display("[TB] FAIL small_reset_pos: got (%0d,%0d) want (0,0)", px2, py2); end
    testsRun++; if ({hs2, vs2, vo2, ls2, fs2} !== 5'b11100) begin testsFailed++; $display("[TB] FAIL small_reset_flags: got hs/vs/vo/ls/fs=%b want 11100", {hs2, vs2, vo2, ls2, fs2}); end
    for (int i = 1; i <= 4; i++) begin
      stepClk();
      if (ls2 !== 1'b0) badLs++;
      if (i == 3) begin
        testsRun++; if (px2 !== 4'd0) begin testsFailed++; $display("[TB] FAIL small_restart_hold: got px=%0d want 0 after 3 clks", px2); end
      end
    end
    testsRun++; if (px2 !== 4'd1) begin testsFailed++; $display("[TB] FAIL small_restart_step: got px=%0d want 1 after 4 clks", px2); end
    testsRun++; if (badLs !== 0) begin testsFailed++; $display("[TB] FAIL small_no_line_start: %0d pulses want 0", badLs); end
    en2 = 1'b0;
  endtask

  task automatic test_div1_800();
    int badTick = 0, badPos = 0, badHs = 0, badVs = 0, badVo = 0, badLs = 0, hsHigh = 0;
    int expPx, expPy;
    rst1 = 1'b1; en1 = 1'b1; stepClk(); rst1 = 1'b0;
    #1;
    testsRun++; if (tk1 !== 1'b1) begin testsFailed++; $display("[TB] FAIL div1_tick_release: got %b want 1", tk1); end
    for (int n = 1; n <= 1100; n++) begin
      stepClk();
      expPx = (n - 1) % 1056; expPy = (n - 1) / 1056;
      if (tk1 !== 1'b1) badTick++;
      if (px1 !== 11'(expPx) || py1 !== 11'(expPy)) badPos++;
      if (hs1 !== (expPx >= 840 && expPx <= 967)) badHs++;
      if (vs1 !== 1'b0) badVs++;
      if (vo1 !== (expPx < 800)) badVo++;
      if (ls1 !== (n == 1057) || fs1 !== 1'b0) badLs++;
      if (hs1 === 1'b1) hsHigh++;
      if (n == 801) begin
        testsRun++; if (vo1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL div1_blank_800: got video_on=%b want 0 at px=%0d", vo1, px1); end
      end
    end
    testsRun++; if (badTick !== 0) begin testsFailed++; $display("[TB] FAIL div1_tick: %0d clks low, want 0", badTick); end
    testsRun++; if (badPos !== 0) begin testsFailed++; $display("[TB] FAIL div1_coords: %0d clks with wrong (x,y), want 0", badPos); end
    testsRun++; if (badHs !== 0) begin testsFailed++; $display("[TB] FAIL div1_hsync: %0d clks wrong, want 0", badHs); end
    testsRun++; if (badVs !== 0) begin testsFailed++; $display("[TB] FAIL div1_vsync: %0d clks wrong, want 0", badVs); end
    testsRun++; if (badVo !== 0) begin testsFailed++; $display("[TB] FAIL div1_video_on: %0d clks wrong, want 0", badVo); end
    testsRun++; if (badLs !== 0) begin testsFailed++; $display("[TB] FAIL div1_pulses: %0d clks wrong, want 0", badLs); end
    testsRun++; if (hsHigh !== 128) begin testsFailed++; $display("[TB] FAIL div1_hsync_width: got %0d clks high want 128", hsHigh); end
    en1 = 1'b0;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    test_reset();
    test_default_line();
    test_enable_freeze();
    test_reset_midline();
    test_small_frames();
    test_small_reset_midframe();
    test_div1_800();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640; visible pixels per line.
REQ-002 Parameter H_FP, default 16; horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 96; horizontal sync width, in pixels.
REQ-004 Parameter H_BP, default 48; horizontal back porch, in pixels.
REQ-005 Parameters V_ACTIVE, V_FP, V_SYNC and V_BP, defaults 480, 10, 2 and 33; the vertical equivalents, in lines.
REQ-006 Parameters H_POL and V_POL, default 0; sync asserted level (0 = active-low).
REQ-007 Parameter CLK_DIV, default 4; clk cycles per pixel, legal range 1..16.
REQ-008 Parameter CW, default 11; coordinate counter width.
REQ-009 clk  input  1  system clock; all logic on its rising edge.
REQ-010 reset  input  1  synchronous, active-high reset.
REQ-011 en  input  1  run enable; when low, the divider and counters hold.
REQ-012 hsync  output  1  registered horizontal sync.
REQ-013 vsync  output  1  registered vertical sync.
REQ-014 video_on  output  1  registered; high only inside the active area.
REQ-015 tick  output  1  pixel clock enable; high for one clk in every CLK_DIV clks.
REQ-016 pixelx  output  CW  registered horizontal coordinate.
REQ-017 pixely  output  CW  registered vertical coordinate.
REQ-018 line_start  output  1  one-clk pulse when pixelx becomes 0.
REQ-019 frame_start  output  1  one-clk pulse when pixelx and pixely both become 0.

Function
REQ-020 The divider SHALL count 0..CLK_DIV-1 while en=1 and assert tick exactly when the count equals CLK_DIV-1; tick SHALL never be high for two consecutive clks unless CLK_DIV=1, in which case tick=en.
REQ-021 The horizontal counter SHALL advance only on a clk where tick=1, wrapping from H_TOTAL-1 to 0; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default).
REQ-022 The vertical counter SHALL advance only on a tick where the horizontal counter equals H_TOTAL-1, wrapping from V_TOTAL-1 to 0; V_TOTAL is the vertical sum (525 by default).
REQ-023 When the horizontal and vertical wraps occur on the same tick, both counters SHALL go to 0 on that clk.
REQ-024 hsync SHALL equal H_POL while pixelx is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751 by default), and ~H_POL otherwise.
REQ-025 vsync SHALL equal V_POL while pixely is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491 by default), and ~V_POL otherwise.
REQ-026 video_on SHALL be (pixelx < H_ACTIVE) and (pixely < V_ACTIVE).
REQ-027 All registered outputs SHALL be mutually aligned: hsync, vsync, video_on, pixelx, pixely, line_start and frame_start describe the same counter state in the same clk, with one clk of latency from the counter update.
REQ-028 line_start SHALL pulse on the single clk in which pixelx changes to 0; frame_start is the subset of these pulses in which pixely is also 0.
REQ-029 When en=0, every counter, the divider and every output SHALL hold its value, except tick, line_start and frame_start, which SHALL be 0.
REQ-030 The arithmetic SHALL be unsigned CW-bit; elaboration SHALL fail if H_TOTAL or V_TOTAL exceeds 2^CW, if any timing parameter is 0, or if CLK_DIV is outside 1..16.

Reset
REQ-031 On reset=1 at a clk edge, the divider count, pixelx and pixely SHALL become 0; tick, line_start and frame_start SHALL become 0; hsync SHALL become ~H_POL and vsync ~V_POL.
REQ-032 On that reset edge, video_on SHALL become 1, consistent with position (0,0).
REQ-033 reset SHALL dominate en and tick; when asserted mid-frame, the first tick after release SHALL move pixelx from 0 to 1.

Structure
REQ-034 A shared package vga_timing_pkg SHALL hold the preset constant sets (640x480@60 and 800x600@60) and a function returning the legality check of REQ-030.
REQ-035 The divider SHALL be a sub-module clk_en_div (parameter CLK_DIV; ports clk, reset, en, tick).
REQ-036 The counters, the compare logic and the output registers SHALL live in vga_timing_gen.

Verification
REQ-037 Defaults, en=1, run 2 frames -> tick every 4 clks; hsync low for 96 ticks starting at pixelx 656; one line = 3200 clks; one frame = 1,680,000 clks.
REQ-038 Defaults -> vsync low exactly while pixely is 490..491; frame_start pulses once per frame, the two pulses 1,680,000 clks apart.
REQ-039 Counters at (799,524), then a tick -> next registered state is (0,0) with line_start=frame_start=1 in the same clk.
REQ-040 en=0 for 37 clks at pixelx=300 -> all outputs frozen, tick=0; after en returns to 1, pixelx reaches 301 after 4 clks.
REQ-041 reset pulsed at pixelx=700, pixely=200 -> next clk shows (0,0), hsync=vsync=1, video_on=1; no line_start pulse.
REQ-042 CLK_DIV=1, H_POL=V_POL=1, 800x600 preset -> tick held high; hsync high while pixelx is 840..967; video_on low at pixelx=800.
